cq_viola_ipl_memory_arbiter: RTL and testbench
==============================================

// Module: cq_viola_ipl_memory_arbiter
// PURPOSE
//  Shares the single-port IPL memory (32-bit x 4096, 1-cycle read latency,
//  unregistered q) between two pipelined Avalon-MM slave ports, s1 and s2.
//  Round-robin arbitration, one command per cycle to memory, registered command
//  stage, in-order read return tagged per port. Sits between the interconnect
//  and the IPL memory.
// PARAMETERS
//  ADDR_WIDTH  12  word address width (memory depth 2**ADDR_WIDTH)
//  DATA_WIDTH  32  data width; byteenable width = DATA_WIDTH/8
// PORTS
//  clk                 in   1    single clock, all logic rising-edge
//  reset_n             in   1    asynchronous, active-low reset
//  s1_address          in   ADDR_WIDTH  s1 word address
//  s1_read             in   1    s1 read request
//  s1_write            in   1    s1 write request
//  s1_byteenable       in   DATA_WIDTH/8  s1 byte lanes
//  s1_writedata        in   DATA_WIDTH  s1 write data
//  s1_waitrequest      out  1    s1 command not accepted this cycle
//  s1_readdata         out  DATA_WIDTH  s1 read data
//  s1_readdatavalid    out  1    s1_readdata valid this cycle
//  s2_*                          identical set for port s2
//  mem_address         out  ADDR_WIDTH  registered command address
//  mem_byteenable      out  DATA_WIDTH/8  registered byte lanes
//  mem_chipselect      out  1    registered command valid
//  mem_write           out  1    registered write strobe
//  mem_writedata       out  DATA_WIDTH  registered write data
//  mem_clken           out  1    tied 1
//  mem_readdata        in   DATA_WIDTH  memory q (valid 1 cycle after command)
// BEHAVIOUR
//  Request: sX_req = sX_read | sX_write. read&write together on one port is
//   illegal; arbiter treats it as a write (read ignored, no readdatavalid).
//  Arbitration (combinational, cycle N): one requester -> grant it. Both ->
//   grant port != last_grant. last_grant updates on every grant.
//   last_grant resets to s2, so s1 wins the first tie.
//  sX_waitrequest = sX_req & ~grant_X. Never asserted when sX_req=0.
//   Accepted command = request with waitrequest low at the clk edge.
//  Command stage (edge ending N): accepted command -> mem_* registers;
//   mem_chipselect=1, mem_write=accepted write. No grant -> mem_chipselect=0,
//   mem_write=0; address/byteenable/writedata hold last value.
//  Read tag pipe: t1 = {valid=accepted read, port} registered with command;
//   t2 <= t1 next edge. Memory samples command at edge ending N+1, drives q in
//   cycle N+2. sX_readdatavalid = t2.valid & (t2.port==X) in cycle N+2.
//   sX_readdata = mem_readdata (both ports, unqualified).
//  Latency: read accepted cycle N -> readdatavalid cycle N+2. Throughput 1
//   command/cycle total; never two readdatavalid in same cycle; returns in
//   acceptance order. Writes produce no response.
//  Back-to-back: write then read same address from either port in consecutive
//   cycles returns new data (single-port memory serialises them).
//  Reset (async assert, any time): mem_chipselect=0, mem_write=0, mem_address=0,
//   mem_byteenable=0, mem_writedata=0, t1/t2 valid=0, last_grant=s2. In-flight
//   reads discarded, no readdatavalid after reset. Waitrequests are
//   combinational and follow requests during reset; commands presented while
//   reset_n=0 are not captured. Deassertion treated as synchronous by the
//   system reset bridge.
//  mem_clken constant 1; no stall path: memory never back-pressures.
// TESTING
//  1 Reset: reset_n=0 mid-read (t1 valid) -> mem_chipselect=0, no
//    readdatavalid on either port after release; first tie grants s1.
//  2 Single port: s1 write addr 0x010 data 0xDEADBEEF be=0xF, then read 0x010
//    -> s1_readdatavalid 2 cycles after read accept, data 0xDEADBEEF.
//  3 Contention: s1 and s2 read 0x000/0x001 continuously for 8 cycles ->
//    grants alternate s1,s2,...; each port 4 accepts, 4 valids, in order.
//  4 Byte lanes: write 0x11223344 be=0xF, then 0xAABBCCDD be=0x5 to 0x0FF ->
//    read returns 0x11BB33DD.
//  5 Cross-port coherence: s2 writes 0x0AB=0x5A5A5A5A cycle N, s1 reads 0x0AB
//    cycle N+1 -> s1 gets 0x5A5A5A5A at N+3.
//  6 Illegal read&write on s2 -> treated as write, s2_readdatavalid stays 0;
//    waitrequest never high without request (assertion whole run).

Source files
------------

// File: rtl/cq_viola_ipl_memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-port IPL memory.
// One registered command per cycle; read data returns to the issuing port two cycles after acceptance.
module cq_viola_ipl_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic                      s1_waitrequest,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic                      s2_waitrequest,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,

    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH/8-1:0]   mem_byteenable,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [DATA_WIDTH-1:0]     mem_writedata,
    output logic                      mem_clken,
    input  logic [DATA_WIDTH-1:0]     mem_readdata
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic PORT_S1 = 1'b0;
    localparam logic PORT_S2 = 1'b1;

    logic                  s1_req;
    logic                  s2_req;
    logic                  grant_1;
    logic                  grant_2;
    logic                  last_grant;

    logic                  cmd_valid;
    logic                  cmd_write;
    logic                  cmd_read;
    logic [ADDR_WIDTH-1:0] cmd_address;
    logic [BE_WIDTH-1:0]   cmd_byteenable;
    logic [DATA_WIDTH-1:0] cmd_writedata;

    logic                  t1_valid;
    logic                  t1_port;
    logic                  t2_valid;
    logic                  t2_port;

    // Round-robin grant: a tie goes to the port that did not win last.
    always_comb begin
        s1_req  = s1_read | s1_write;
        s2_req  = s2_read | s2_write;
        grant_1 = s1_req & (~s2_req | (last_grant == PORT_S2));
        grant_2 = s2_req & ~grant_1;
    end

    // Winning command; a simultaneous read+write is taken as a write only.
    always_comb begin
        cmd_valid      = grant_1 | grant_2;
        cmd_write      = s1_write;
        cmd_read       = s1_read & ~s1_write;
        cmd_address    = s1_address;
        cmd_byteenable = s1_byteenable;
        cmd_writedata  = s1_writedata;
        if (grant_2) begin
            cmd_write      = s2_write;
            cmd_read       = s2_read & ~s2_write;
            cmd_address    = s2_address;
            cmd_byteenable = s2_byteenable;
            cmd_writedata  = s2_writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant     <= PORT_S2;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            t1_valid       <= 1'b0;
            t1_port        <= PORT_S1;
        end else begin
            mem_chipselect <= cmd_valid;
            mem_write      <= cmd_valid & cmd_write;
            t1_valid       <= cmd_valid & cmd_read;
            if (cmd_valid) begin
                last_grant     <= grant_2 ? PORT_S2 : PORT_S1;
                mem_address    <= cmd_address;
                mem_byteenable <= cmd_byteenable;
                mem_writedata  <= cmd_writedata;
                t1_port        <= grant_2 ? PORT_S2 : PORT_S1;
            end
        end
    end

    // Second tag stage lines up with the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t2_valid <= 1'b0;
            t2_port  <= PORT_S1;
        end else begin
            t2_valid <= t1_valid;
            t2_port  <= t1_port;
        end
    end

    always_comb begin
        s1_waitrequest   = s1_req & ~grant_1;
        s2_waitrequest   = s2_req & ~grant_2;
        s1_readdatavalid = t2_valid & (t2_port == PORT_S1);
        s2_readdatavalid = t2_valid & (t2_port == PORT_S2);
        s1_readdata      = mem_readdata;
        s2_readdata      = mem_readdata;
        mem_clken        = 1'b1;
    end

endmodule

// File: tb/tb_cq_viola_ipl_memory_arbiter.sv
// Directed cycle table plus hand-written reset and illegal-command sequences for the IPL memory arbiter.
module tb_cq_viola_ipl_memory_arbiter;

    localparam int NV = 27;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] s1_address, s2_address;
    logic        s1_read, s1_write, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic        s1_waitrequest, s2_waitrequest;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int checks = 0;
    int errors = 0;

    cq_viola_ipl_memory_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .s2_address(s2_address), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata),
        .s2_readdatavalid(s2_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: command sampled at the edge, q registered.
    logic [31:0] ram [0:4095];
    logic [31:0] ram_q = 32'h0;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    // Whole-run protocol monitor.
    always @(negedge clk) begin
        checks++;
        if (s1_waitrequest && !(s1_read || s1_write)) begin
            errors++;
            $display("FAIL s1_wait_without_req actual=1 required=0 t=%0t", $time);
        end
        checks++;
        if (s2_waitrequest && !(s2_read || s2_write)) begin
            errors++;
            $display("FAIL s2_wait_without_req actual=1 required=0 t=%0t", $time);
        end
        checks++;
        if (s1_readdatavalid && s2_readdatavalid) begin
            errors++;
            $display("FAIL dual_readdatavalid actual=1 required=0 t=%0t", $time);
        end
    end

    typedef struct {
        logic        s1_rd, s1_wr;
        logic [11:0] s1_addr;
        logic [3:0]  s1_be;
        logic [31:0] s1_wd;
        logic        s2_rd, s2_wr;
        logic [11:0] s2_addr;
        logic [3:0]  s2_be;
        logic [31:0] s2_wd;
        logic        e_w1, e_w2, e_v1, e_v2, e_cs, e_mw;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmd1(input int i, input logic rd, input logic wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        vecs[i].s1_rd = rd; vecs[i].s1_wr = wr; vecs[i].s1_addr = a;
        vecs[i].s1_be = be; vecs[i].s1_wd = wd;
    endtask

    task automatic cmd2(input int i, input logic rd, input logic wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        vecs[i].s2_rd = rd; vecs[i].s2_wr = wr; vecs[i].s2_addr = a;
        vecs[i].s2_be = be; vecs[i].s2_wd = wd;
    endtask

    task automatic ex(input int i, input logic w1, input logic w2, input logic v1, input logic v2,
                      input logic cs, input logic mw, input logic [31:0] d);
        vecs[i].e_w1 = w1; vecs[i].e_w2 = w2; vecs[i].e_v1 = v1; vecs[i].e_v2 = v2;
        vecs[i].e_cs = cs; vecs[i].e_mw = mw; vecs[i].e_data = d;
    endtask

    task automatic idle();
        s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();

        for (int i = 0; i < NV; i++) begin
            cmd1(i, 0, 0, 12'h0, 4'h0, 32'h0);
            cmd2(i, 0, 0, 12'h0, 4'h0, 32'h0);
            ex(i, 0, 0, 0, 0, 0, 0, 32'h0);
        end
        // Single-port write/read, byte lanes, cross-port coherence, then contention.
        cmd1(1, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        cmd1(2, 1, 0, 12'h010, 4'hF, 32'h0);
        cmd1(5, 0, 1, 12'h0FF, 4'hF, 32'h11223344);
        cmd1(6, 0, 1, 12'h0FF, 4'h5, 32'hAABBCCDD);
        cmd1(7, 1, 0, 12'h0FF, 4'hF, 32'h0);
        cmd2(10, 0, 1, 12'h0AB, 4'hF, 32'h5A5A5A5A);
        cmd1(11, 1, 0, 12'h0AB, 4'hF, 32'h0);
        cmd1(14, 0, 1, 12'h000, 4'hF, 32'h00000A0A);
        cmd2(15, 0, 1, 12'h001, 4'hF, 32'h0000B1B1);
        for (int i = 16; i < 24; i++) begin
            cmd1(i, 1, 0, 12'h000, 4'hF, 32'h0);
            cmd2(i, 1, 0, 12'h001, 4'hF, 32'h0);
        end
        ex(2,  0, 0, 0, 0, 1, 1, 32'h0);
        ex(3,  0, 0, 0, 0, 1, 0, 32'h0);
        ex(4,  0, 0, 1, 0, 0, 0, 32'hDEADBEEF);
        ex(6,  0, 0, 0, 0, 1, 1, 32'h0);
        ex(7,  0, 0, 0, 0, 1, 1, 32'h0);
        ex(8,  0, 0, 0, 0, 1, 0, 32'h0);
        ex(9,  0, 0, 1, 0, 0, 0, 32'h11BB33DD);
        ex(11, 0, 0, 0, 0, 1, 1, 32'h0);
        ex(12, 0, 0, 0, 0, 1, 0, 32'h0);
        ex(13, 0, 0, 1, 0, 0, 0, 32'h5A5A5A5A);
        ex(15, 0, 0, 0, 0, 1, 1, 32'h0);
        ex(16, 0, 1, 0, 0, 1, 1, 32'h0);
        ex(17, 1, 0, 0, 0, 1, 0, 32'h0);
        ex(18, 0, 1, 1, 0, 1, 0, 32'h00000A0A);
        ex(19, 1, 0, 0, 1, 1, 0, 32'h0000B1B1);
        ex(20, 0, 1, 1, 0, 1, 0, 32'h00000A0A);
        ex(21, 1, 0, 0, 1, 1, 0, 32'h0000B1B1);
        ex(22, 0, 1, 1, 0, 1, 0, 32'h00000A0A);
        ex(23, 1, 0, 0, 1, 1, 0, 32'h0000B1B1);
        ex(24, 0, 0, 1, 0, 1, 0, 32'h00000A0A);
        ex(25, 0, 0, 0, 1, 0, 0, 32'h0000B1B1);

        // Power-on reset values.
        repeat (3) @(negedge clk);
        chk("rst_mem_chipselect", 32'(mem_chipselect), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_address", 32'(mem_address), 32'h0);
        chk("rst_mem_byteenable", 32'(mem_byteenable), 32'h0);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        chk("mem_clken", 32'(mem_clken), 32'h1);
        chk("rst_s1_rdv", 32'(s1_readdatavalid), 32'h0);
        chk("rst_s2_rdv", 32'(s2_readdatavalid), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            next_cycle();
            s1_read = vecs[i].s1_rd; s1_write = vecs[i].s1_wr; s1_address = vecs[i].s1_addr;
            s1_byteenable = vecs[i].s1_be; s1_writedata = vecs[i].s1_wd;
            s2_read = vecs[i].s2_rd; s2_write = vecs[i].s2_wr; s2_address = vecs[i].s2_addr;
            s2_byteenable = vecs[i].s2_be; s2_writedata = vecs[i].s2_wd;
            @(negedge clk);
            chk($sformatf("v%0d_s1_wait", i), 32'(s1_waitrequest), 32'(vecs[i].e_w1));
            chk($sformatf("v%0d_s2_wait", i), 32'(s2_waitrequest), 32'(vecs[i].e_w2));
            chk($sformatf("v%0d_s1_rdv", i), 32'(s1_readdatavalid), 32'(vecs[i].e_v1));
            chk($sformatf("v%0d_s2_rdv", i), 32'(s2_readdatavalid), 32'(vecs[i].e_v2));
            chk($sformatf("v%0d_mem_cs", i), 32'(mem_chipselect), 32'(vecs[i].e_cs));
            chk($sformatf("v%0d_mem_wr", i), 32'(mem_write), 32'(vecs[i].e_mw));
            if (vecs[i].e_v1) chk($sformatf("v%0d_s1_data", i), s1_readdata, vecs[i].e_data);
            if (vecs[i].e_v2) chk($sformatf("v%0d_s2_data", i), s2_readdata, vecs[i].e_data);
        end

        // Illegal read+write on s2 behaves as a plain write.
        next_cycle();
        idle();
        s2_read = 1; s2_write = 1; s2_address = 12'h020; s2_byteenable = 4'hF; s2_writedata = 32'h12345678;
        @(negedge clk);
        chk("rw_s2_wait", 32'(s2_waitrequest), 32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rw_mem_cs", 32'(mem_chipselect), 32'h1);
        chk("rw_mem_write", 32'(mem_write), 32'h1);
        chk("rw_mem_address", 32'(mem_address), 32'h020);
        chk("rw_mem_writedata", mem_writedata, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rw_no_rdv%0d", k), 32'(s2_readdatavalid), 32'h0);
        end
        next_cycle();
        s2_read = 1; s2_address = 12'h020; s2_byteenable = 4'hF;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        chk("rw_readback_rdv", 32'(s2_readdatavalid), 32'h1);
        chk("rw_readback_data", s2_readdata, 32'h12345678);

        // Reset with a read in flight discards it and restores s1 tie priority.
        next_cycle();
        s1_read = 1; s1_address = 12'h010; s1_byteenable = 4'hF;
        next_cycle();
        idle();
        chk("inflight_cs", 32'(mem_chipselect), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_cs", 32'(mem_chipselect), 32'h0);
        chk("async_rst_address", 32'(mem_address), 32'h0);
        chk("async_rst_writedata", mem_writedata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_s1_rdv%0d", k), 32'(s1_readdatavalid), 32'h0);
            chk($sformatf("post_rst_s2_rdv%0d", k), 32'(s2_readdatavalid), 32'h0);
        end
        next_cycle();
        s1_read = 1; s1_address = 12'h000; s1_byteenable = 4'hF;
        s2_read = 1; s2_address = 12'h001; s2_byteenable = 4'hF;
        @(negedge clk);
        chk("post_rst_tie_s1_wait", 32'(s1_waitrequest), 32'h0);
        chk("post_rst_tie_s2_wait", 32'(s2_waitrequest), 32'h1);
        next_cycle();
        idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
